// File: rtl/rx_pkg.sv
// Shared receiver constants and FIFO helper types.
// Used by rx_fifo and the receiver top level.
package rx_pkg;

  localparam int FIFO_DEPTH = 8;
  localparam int FIFO_WIDTH = 8;
  localparam int PTR_W      = 3;
  localparam int CNT_W      = 4;

  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

  function automatic fifo_op_e fifo_op(
    input logic wr,
    input logic rd
  );
    return fifo_op_e'({wr, rd});
  endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Wrapping pointer counter with enable and
// synchronous clear, shared by read and write sides.
module fifo_ptr
  import rx_pkg::*;
#(
  parameter int W = PTR_W
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] ptr
);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      ptr <= '0;
    end else if (clr) begin
      ptr <= '0;
    end else if (en) begin
      ptr <= ptr + 1'b1;
    end
  end

endmodule

// File: rtl/rx_fifo.sv
// Receive FIFO: first-word-fall-through byte
// buffer with sticky overrun flag and flush.
module rx_fifo
  import rx_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH,
  parameter int WIDTH = FIFO_WIDTH
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             w_enable,
  input  logic [WIDTH-1:0] w_data,
  input  logic             r_enable,
  input  logic             clear,
  output logic [WIDTH-1:0] r_data,
  output logic             empty,
  output logic             full,
  output logic [3:0]       count,
  output logic             overrun
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic             wr_ok;
  logic             rd_ok;
  logic             drop;
  logic [3:0]       count_nxt;

  assign empty = (count == 4'd0);
  assign full  = (count == 4'(DEPTH));

  // A full FIFO still takes a write if a pop
  // frees the head slot in the same cycle.
  assign wr_ok = w_enable & (~full | r_enable);
  assign rd_ok = r_enable & ~empty;
  assign drop  = w_enable & full & ~r_enable;

  assign r_data = mem[rptr];

  fifo_ptr #(.W(PTR_W)) u_wptr (
    .clk   (clk),
    .n_rst (n_rst),
    .en    (wr_ok),
    .clr   (clear),
    .ptr   (wptr)
  );

  fifo_ptr #(.W(PTR_W)) u_rptr (
    .clk   (clk),
    .n_rst (n_rst),
    .en    (rd_ok),
    .clr   (clear),
    .ptr   (rptr)
  );

  always_ff @(posedge clk) begin
    if (wr_ok && !clear) begin
      mem[wptr] <= w_data;
    end
  end

  always_comb begin
    count_nxt = count;
    if (clear) begin
      count_nxt = 4'd0;
    end else begin
      unique case (fifo_op(wr_ok, rd_ok))
        OP_PUSH: count_nxt = count + 4'd1;
        OP_POP:  count_nxt = count - 4'd1;
        OP_BOTH: count_nxt = count;
        OP_IDLE: count_nxt = count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count <= 4'd0;
    end else begin
      count <= count_nxt;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      overrun <= 1'b0;
    end else if (clear) begin
      overrun <= 1'b0;
    end else if (drop) begin
      overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rx_fifo.sv
// Self-checking bench for rx_fifo: vector table,
// directed corner sequences, random vs queue model.
module tb_rx_fifo;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       w_enable = 1'b0;
  logic [7:0] w_data = 8'h00;
  logic       r_enable = 1'b0;
  logic       clear = 1'b0;
  logic [7:0] r_data;
  logic       empty;
  logic       full;
  logic [3:0] count;
  logic       overrun;

  int total = 0;
  int bad = 0;

  logic [7:0] q[$];
  bit         m_ovr = 1'b0;

  typedef struct {
    bit       clr;
    bit       we;
    bit [7:0] wd;
    bit       re;
    int       cnt;
    bit       emp;
    bit       ful;
    bit       ovr;
    bit       rd_chk;
    bit [7:0] rd;
  } vec_t;

  vec_t vecs[$];

  rx_fifo dut (
    .clk      (clk),
    .n_rst    (n_rst),
    .w_enable (w_enable),
    .w_data   (w_data),
    .r_enable (r_enable),
    .clear    (clear),
    .r_data   (r_data),
    .empty    (empty),
    .full     (full),
    .count    (count),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference: a queue of bytes plus a sticky bit.
  task automatic model(input bit c, input bit we,
                       input logic [7:0] wd, input bit re);
    bit was_full;
    bit was_empty;
    if (c) begin
      q.delete();
      m_ovr = 1'b0;
      return;
    end
    was_full = (q.size() == 8);
    was_empty = (q.size() == 0);
    if (we && was_full && !re) m_ovr = 1'b1;
    if (re && !was_empty) void'(q.pop_front());
    if (we && (!was_full || re)) q.push_back(wd);
  endtask

  task automatic step(input bit c, input bit we,
                      input logic [7:0] wd, input bit re);
    clear = c;
    w_enable = we;
    w_data = wd;
    r_enable = re;
    @(posedge clk);
    #1;
    model(c, we, wd, re);
    clear = 1'b0;
    w_enable = 1'b0;
    r_enable = 1'b0;
  endtask

  task automatic chk_model(input string nm);
    chk({nm, ".count"}, 32'(count), 32'(q.size()));
    chk({nm, ".empty"}, 32'(empty), 32'(q.size() == 0));
    chk({nm, ".full"}, 32'(full), 32'(q.size() == 8));
    chk({nm, ".overrun"}, 32'(overrun), 32'(m_ovr));
    if (q.size() != 0) chk({nm, ".r_data"}, 32'(r_data), 32'(q[0]));
  endtask

  function automatic vec_t mk(bit c, bit we, bit [7:0] wd, bit re,
                              int cnt, bit ovr, bit rc, bit [7:0] rd);
    vec_t v;
    v.clr = c;
    v.we = we;
    v.wd = wd;
    v.re = re;
    v.cnt = cnt;
    v.emp = (cnt == 0);
    v.ful = (cnt == 8);
    v.ovr = ovr;
    v.rd_chk = rc;
    v.rd = rd;
    return v;
  endfunction

  initial begin
    // Single byte through, then pop, then pop on empty.
    vecs.push_back(mk(0, 1, 8'hA5, 0, 1, 0, 1, 8'hA5));
    vecs.push_back(mk(0, 0, 8'h00, 1, 0, 0, 0, 8'h00));
    vecs.push_back(mk(0, 0, 8'h00, 1, 0, 0, 0, 8'h00));
    // Fill with 01..08, head stays 01.
    for (int i = 1; i <= 8; i++)
      vecs.push_back(mk(0, 1, 8'(i), 0, i, 0, 1, 8'h01));
    // Overflow write is dropped.
    vecs.push_back(mk(0, 1, 8'hFF, 0, 8, 1, 1, 8'h01));
    // Drain: head walks 02..08, overrun sticks.
    for (int i = 1; i <= 8; i++)
      vecs.push_back(mk(0, 0, 8'h00, 1, 8 - i, 1,
                        i < 8, 8'(i + 1)));
    // Pop on empty while overrun set: no change.
    vecs.push_back(mk(0, 0, 8'h00, 1, 0, 1, 0, 8'h00));
    vecs.push_back(mk(1, 0, 8'h00, 0, 0, 0, 0, 8'h00));
  end

  initial begin
    int n;
    logic [7:0] b;
    bit c, we, re;

    #12;
    chk("rst.count", 32'(count), 0);
    chk("rst.empty", 32'(empty), 1);
    chk("rst.full", 32'(full), 0);
    chk("rst.overrun", 32'(overrun), 0);
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      step(vecs[i].clr, vecs[i].we, vecs[i].wd, vecs[i].re);
      chk($sformatf("vec%0d.count", i), 32'(count), 32'(vecs[i].cnt));
      chk($sformatf("vec%0d.empty", i), 32'(empty), 32'(vecs[i].emp));
      chk($sformatf("vec%0d.full", i), 32'(full), 32'(vecs[i].ful));
      chk($sformatf("vec%0d.ovr", i), 32'(overrun), 32'(vecs[i].ovr));
      if (vecs[i].rd_chk)
        chk($sformatf("vec%0d.rdata", i), 32'(r_data), 32'(vecs[i].rd));
    end

    // Full + simultaneous push/pop keeps count at 8.
    for (int i = 0; i < 8; i++) step(0, 1, 8'(8'h60 + i), 0);
    step(0, 1, 8'h55, 1);
    chk("both_full.count", 32'(count), 8);
    chk("both_full.ovr", 32'(overrun), 0);
    chk_model("both_full");
    for (int i = 0; i < 8; i++) begin
      b = r_data;
      step(0, 0, 8'h00, 1);
    end
    chk("both_full.last", 32'(b), 32'h55);
    chk("both_full.empty", 32'(empty), 1);

    // Wrap-around across pointer 7->0.
    step(1, 0, 8'h00, 0);
    for (int i = 0; i < 6; i++) begin
      step(0, 1, 8'(8'hC0 + i), 0);
      step(0, 0, 8'h00, 1);
    end
    for (int i = 0; i < 8; i++) step(0, 1, 8'(8'h10 + i), 0);
    chk("wrap.full", 32'(full), 1);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("wrap.pop%0d", i), 32'(r_data), 32'(8'h10 + i));
      step(0, 0, 8'h00, 1);
    end
    chk("wrap.empty", 32'(empty), 1);

    // Clear beats a simultaneous write and drops overrun.
    for (int i = 0; i < 9; i++) step(0, 1, 8'(i), 0);
    for (int i = 0; i < 5; i++) step(0, 0, 8'h00, 1);
    chk("clr.pre_count", 32'(count), 3);
    chk("clr.pre_ovr", 32'(overrun), 1);
    step(1, 1, 8'h33, 0);
    chk("clr.count", 32'(count), 0);
    chk("clr.empty", 32'(empty), 1);
    chk("clr.ovr", 32'(overrun), 0);
    step(0, 0, 8'h00, 0);
    chk("clr.not_stored", 32'(count), 0);

    // Random traffic against the queue model.
    for (int i = 0; i < 800; i++) begin
      c = ($urandom_range(0, 99) < 2);
      we = ($urandom_range(0, 99) < 55);
      re = ($urandom_range(0, 99) < 45);
      step(c, we, 8'($urandom), re);
      chk_model($sformatf("rnd%0d", i));
    end

    // Asynchronous reset mid-stream with five entries.
    step(1, 0, 8'h00, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 8'(8'hE0 + i), 0);
    chk("arst.pre", 32'(count), 5);
    #2;
    n_rst = 1'b0;
    #1;
    chk("arst.count", 32'(count), 0);
    chk("arst.empty", 32'(empty), 1);
    chk("arst.full", 32'(full), 0);
    chk("arst.ovr", 32'(overrun), 0);
    q.delete();
    m_ovr = 1'b0;
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    step(0, 1, 8'h9C, 0);
    chk_model("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
